hiscore_xfer: RTL and testbench

- Initiator side of the video block's hiscore port (HSAD/HSDI/HSDO/HSWE/PAUSE_N).
- Halts the game through PAUSE_N, then walks a byte range of sprite RAM or VRAM.
- Dump: reads each byte out of the range onto a valid/ready byte stream toward the save path.
- Restore: writes bytes taken from a valid/ready input stream back into the range, then releases the pause.

---
 rtl/hiscore_pkg.sv | 30 +++
 rtl/hiscore_addr_ctr.sv | 63 ++++++
 rtl/hiscore_xfer.sv | 216 +++++++++++++++++++++
 tb/tb_hiscore_xfer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_pkg.sv
// rtl/hiscore_pkg.sv - shared states, modes and hiscore window constants
// Ports: none (package).
package hiscore_pkg;

  localparam int HS_SETTLE = 4;
  localparam int HS_RD_LAT = 1;
  localparam int HS_LEN_W  = 11;

  localparam logic [15:0] HS_SPRAM_BASE = 16'hD000;
  localparam logic [15:0] HS_VRAM0_BASE = 16'hE000;
  localparam logic [15:0] HS_VRAM1_BASE = 16'hE800;
  localparam int          HS_WIN_SIZE   = 2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_PUSH,
    ST_WR_WAIT,
    ST_WR_STROBE,
    ST_RELEASE
  } hs_state_t;

  typedef enum logic {
    HS_MODE_DUMP,
    HS_MODE_LOAD
  } hs_mode_t;

endpackage

// File: rtl/hiscore_addr_ctr.sv
// rtl/hiscore_addr_ctr.sv - base/length latch, byte index counter and wrapping address
// Ports:
//   clk, RESET          clock, synchronous active-high reset
//   load                latch base_in/len_in and clear the index
//   base_in, len_in     transfer window sampled on load
//   inc                 advance the index by one byte
//   addr                base + idx, wrapping mod 2^16
//   addr_inc            base + idx + 1, wrapping (address of the next byte)
//   last                idx is the final byte (idx == len-1); meaningless when len == 0
//   len_zero            latched length is zero
module hiscore_addr_ctr
  import hiscore_pkg::*;
#(
  parameter int LEN_W = HS_LEN_W
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             load,
  input  logic [15:0]      base_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             inc,
  output logic [15:0]      addr,
  output logic [15:0]      addr_inc,
  output logic             last,
  output logic             len_zero
);

  logic [15:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;

  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    idx_d  = idx_q;
    if (load) begin
      base_d = base_in;
      len_d  = len_in;
      idx_d  = '0;
    end else if (inc) begin
      idx_d = idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

  // The 16-bit add wraps naturally, so a window straddling FFFF continues at 0000.
  assign addr     = base_q + 16'(idx_q);
  assign addr_inc = addr + 16'd1;
  assign len_zero = (len_q == '0);
  assign last     = (idx_q == (len_q - LEN_W'(1)));

endmodule

// File: rtl/hiscore_xfer.sv
// rtl/hiscore_xfer.sv - hiscore port initiator: pause game, dump or restore a RAM byte range
// Ports:
//   clk, RESET                 clock, synchronous active-high reset
//   dump_req, load_req         start pulses (dump has priority); ignored while busy
//   cfg_base, cfg_len          window start address and byte count, sampled at start
//   busy, done                 transfer in progress / one-clock completion pulse
//   PAUSE_N, HSAD, HSDI, HSWE  hiscore port toward the video block
//   HSDO                       registered read data from the video block
//   out_dat/out_vld/out_rdy    dump byte stream
//   in_dat/in_vld/in_rdy       restore byte stream (in_rdy high exactly during the HSWE clock)
module hiscore_xfer
  import hiscore_pkg::*;
#(
  parameter int SETTLE = HS_SETTLE,
  parameter int RD_LAT = HS_RD_LAT,
  parameter int LEN_W  = HS_LEN_W
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             dump_req,
  input  logic             load_req,
  input  logic [15:0]      cfg_base,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  output logic             PAUSE_N,
  output logic [15:0]      HSAD,
  output logic [7:0]       HSDI,
  output logic             HSWE,
  input  logic [7:0]       HSDO,
  output logic [7:0]       out_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  input  logic [7:0]       in_dat,
  input  logic             in_vld,
  output logic             in_rdy
);

  localparam int CNT_W = 8;

  hs_state_t        state_q, state_d;
  hs_mode_t         mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pause_n_q, pause_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hswe_q, hswe_d;
  logic             in_rdy_q, in_rdy_d;
  logic [7:0]       hsdi_q, hsdi_d;
  logic [7:0]       out_dat_q, out_dat_d;
  logic             out_vld_q, out_vld_d;
  logic [15:0]      hsad_q, hsad_d;

  logic             ctr_load, ctr_inc;
  logic [15:0]      ctr_addr, ctr_addr_inc;
  logic             ctr_last, ctr_len_zero;

  hiscore_addr_ctr #(.LEN_W(LEN_W)) u_addr_ctr (
    .clk      (clk),
    .RESET    (RESET),
    .load     (ctr_load),
    .base_in  (cfg_base),
    .len_in   (cfg_len),
    .inc      (ctr_inc),
    .addr     (ctr_addr),
    .addr_inc (ctr_addr_inc),
    .last     (ctr_last),
    .len_zero (ctr_len_zero)
  );

  // HSAD is loaded on the edge that enters RD_ADDR / WR_WAIT, so the address is
  // already on the port during those states; with the RAM's registered read the
  // byte is then ready by the last RD_WAIT clock.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    pause_n_d = pause_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hswe_d    = hswe_q;
    in_rdy_d  = in_rdy_q;
    hsdi_d    = hsdi_q;
    out_dat_d = out_dat_q;
    out_vld_d = out_vld_q;
    hsad_d    = hsad_q;
    ctr_load  = 1'b0;
    ctr_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dump_req || load_req) begin
          mode_d    = dump_req ? HS_MODE_DUMP : HS_MODE_LOAD;
          ctr_load  = 1'b1;
          pause_n_d = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d = '0;
          if (ctr_len_zero) begin
            state_d = ST_RELEASE;
          end else begin
            hsad_d  = ctr_addr;
            state_d = (mode_q == HS_MODE_DUMP) ? ST_RD_ADDR : ST_WR_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RD_ADDR: begin
        cnt_d   = '0;
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          out_dat_d = HSDO;
          out_vld_d = 1'b1;
          state_d   = ST_RD_PUSH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RD_PUSH: begin
        if (out_rdy) begin
          out_vld_d = 1'b0;
          ctr_inc   = 1'b1;
          if (ctr_last) begin
            state_d = ST_RELEASE;
          end else begin
            hsad_d  = ctr_addr_inc;
            state_d = ST_RD_ADDR;
          end
        end
      end

      ST_WR_WAIT: begin
        if (in_vld) begin
          hsdi_d   = in_dat;
          hswe_d   = 1'b1;
          in_rdy_d = 1'b1;
          state_d  = ST_WR_STROBE;
        end
      end

      ST_WR_STROBE: begin
        hswe_d   = 1'b0;
        in_rdy_d = 1'b0;
        ctr_inc  = 1'b1;
        if (ctr_last) begin
          state_d = ST_RELEASE;
        end else begin
          hsad_d  = ctr_addr_inc;
          state_d = ST_WR_WAIT;
        end
      end

      ST_RELEASE: begin
        pause_n_d = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      mode_q    <= HS_MODE_DUMP;
      cnt_q     <= '0;
      pause_n_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hswe_q    <= 1'b0;
      in_rdy_q  <= 1'b0;
      hsdi_q    <= '0;
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
      hsad_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      pause_n_q <= pause_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hswe_q    <= hswe_d;
      in_rdy_q  <= in_rdy_d;
      hsdi_q    <= hsdi_d;
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
      hsad_q    <= hsad_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign PAUSE_N = pause_n_q;
  assign HSAD    = hsad_q;
  assign HSDI    = hsdi_q;
  assign HSWE    = hswe_q;
  assign out_dat = out_dat_q;
  assign out_vld = out_vld_q;
  assign in_rdy  = in_rdy_q;

endmodule

// File: tb/tb_hiscore_xfer.sv
// tb/tb_hiscore_xfer.sv - directed self-checking bench for hiscore_xfer
module tb_hiscore_xfer;
  import hiscore_pkg::*;

  logic        clk = 1'b0;
  logic        RESET;
  logic        dump_req, load_req;
  logic [15:0] cfg_base;
  logic [10:0] cfg_len;
  logic        busy, done, PAUSE_N, HSWE;
  logic [15:0] HSAD;
  logic [7:0]  HSDI, HSDO;
  logic [7:0]  out_dat, in_dat;
  logic        out_vld, out_rdy, in_vld, in_rdy;

  logic        pre_we;
  logic [15:0] pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  // event logs kept by the negedge monitor
  int          done_cnt = 0, hswe_cnt = 0, ovld_cnt = 0, rdy_mis = 0, hswe_unpaused = 0;
  logic [7:0]  out_log [$];
  logic [23:0] wr_log [$];
  logic [15:0] addr_log [$];
  logic [15:0] hsad_prev = 16'h0;

  always #5 clk = ~clk;

  hiscore_xfer dut (
    .clk      (clk),
    .RESET    (RESET),
    .dump_req (dump_req),
    .load_req (load_req),
    .cfg_base (cfg_base),
    .cfg_len  (cfg_len),
    .busy     (busy),
    .done     (done),
    .PAUSE_N  (PAUSE_N),
    .HSAD     (HSAD),
    .HSDI     (HSDI),
    .HSWE     (HSWE),
    .HSDO     (HSDO),
    .out_dat  (out_dat),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .in_dat   (in_dat),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy)
  );

  // video-side RAM with a one-clock registered read port
  always @(posedge clk) begin
    HSDO <= mem[HSAD];
    if (pre_we) mem[pre_a] <= pre_d;
    else if (HSWE && !PAUSE_N) mem[HSAD] <= HSDI;
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (out_vld) ovld_cnt <= ovld_cnt + 1;
    if (out_vld && out_rdy) out_log.push_back(out_dat);
    if (HSWE) begin
      hswe_cnt <= hswe_cnt + 1;
      wr_log.push_back({HSAD, HSDI});
    end
    if (in_rdy !== HSWE) rdy_mis <= rdy_mis + 1;
    if (HSWE && PAUSE_N) hswe_unpaused <= hswe_unpaused + 1;
    if (HSAD !== hsad_prev) addr_log.push_back(HSAD);
    hsad_prev <= HSAD;
  end

  function automatic logic [7:0] ob(input int i);
    return (i < out_log.size()) ? out_log[i] : 8'hEE;
  endfunction

  function automatic logic [15:0] ab(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 16'hDEAD;
  endfunction

  function automatic logic [23:0] wb(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 24'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic start(input logic dmp, input logic ld, input logic [15:0] base, input logic [10:0] len);
    cfg_base = base;
    cfg_len  = len;
    dump_req = dmp;
    load_req = ld;
    tick();
    dump_req = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int m);
    m = 0;
    do begin
      tick();
      m++;
    end while (!done && m < 200);
    check(tag, 32'(done), 32'h1);
  endtask

  // presents one restore byte after gap idle clocks and completes its handshake
  task automatic push_byte(input string tag, input int gap, input logic [7:0] b);
    int n;
    in_vld = 1'b0;
    repeat (gap) tick();
    in_vld = 1'b1;
    in_dat = b;
    n = 0;
    do begin
      tick();
      n++;
    end while (!in_rdy && n < 50);
    check(tag, 32'(in_rdy), 32'h1);
    tick();
    in_vld = 1'b0;
  endtask

  initial begin
    int n, m, o0, a0, d0, w0, v0;
    logic [15:0] h_old;

    RESET = 1'b1; dump_req = 1'b0; load_req = 1'b0; cfg_base = '0; cfg_len = '0;
    out_rdy = 1'b1; in_dat = '0; in_vld = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    tick();
    tick();
    check("rst_ctrl", 32'({PAUSE_N, busy, done, HSWE, out_vld, in_rdy}), 32'b100000);
    check("rst_hsad", 32'(HSAD), 32'h0);
    check("rst_data", 32'({HSDI, out_dat}), 32'h0);
    RESET = 1'b0;

    poke(16'hD000, 8'h11); poke(16'hD001, 8'h22); poke(16'hD002, 8'h33); poke(16'hD003, 8'h44);
    poke(16'hD100, 8'hC1); poke(16'hD101, 8'hC2);
    poke(16'hFFFF, 8'h77); poke(16'h0000, 8'h88);

    // dump D000, len 4
    o0 = out_log.size(); a0 = addr_log.size(); d0 = done_cnt; w0 = hswe_cnt;
    h_old = HSAD;
    start(1'b1, 1'b0, HS_SPRAM_BASE, 11'd4);
    check("d1_busy", 32'({busy, PAUSE_N}), 32'b10);
    n = 0;
    while (PAUSE_N == 1'b0 && HSAD == h_old && n < 50) begin
      n++;
      tick();
    end
    check("d1_settle", 32'(n), 32'(HS_SETTLE));
    wait_done("d1_done", m);
    // settle + 4 bytes at RD_LAT+2 clocks each + one RELEASE clock
    check("d1_cycles", 32'(n + m), 32'(HS_SETTLE + 4 * (HS_RD_LAT + 2) + 1));
    check("d1_release", 32'({PAUSE_N, busy}), 32'b10);
    check("d1_bytes", {ob(o0), ob(o0 + 1), ob(o0 + 2), ob(o0 + 3)}, 32'h11223344);
    check("d1_addr01", {ab(a0), ab(a0 + 1)}, 32'hD000D001);
    check("d1_addr23", {ab(a0 + 2), ab(a0 + 3)}, 32'hD002D003);
    tick(); tick();
    check("d1_nbytes", 32'(out_log.size() - o0), 32'h4);
    check("d1_done_once", 32'(done_cnt - d0), 32'h1);
    check("d1_no_hswe", 32'(hswe_cnt - w0), 32'h0);

    // restore E800, len 3, gaps 0/3/1
    w0 = hswe_cnt; d0 = done_cnt;
    start(1'b0, 1'b1, HS_VRAM1_BASE, 11'd3);
    push_byte("r_b0_rdy", 0, 8'hA5);
    push_byte("r_b1_rdy", 3, 8'h5A);
    push_byte("r_b2_rdy", 1, 8'hFF);
    wait_done("r_done", m);
    tick(); tick();
    check("r_nwr", 32'(hswe_cnt - w0), 32'h3);
    check("r_wr0", 32'(wb(w0)), 32'hE800A5);
    check("r_wr1", 32'(wb(w0 + 1)), 32'hE8015A);
    check("r_wr2", 32'(wb(w0 + 2)), 32'hE802FF);
    check("r_done_once", 32'(done_cnt - d0), 32'h1);
    check("r_mem", 32'({mem[16'hE800], mem[16'hE801], mem[16'hE802]}), 32'hA55AFF);

    // readback through a dump of the same window
    o0 = out_log.size();
    start(1'b1, 1'b0, HS_VRAM1_BASE, 11'd3);
    wait_done("rb_done", m);
    check("rb_bytes", 32'({ob(o0), ob(o0 + 1), ob(o0 + 2)}), 32'hA55AFF);

    // backpressure: out_rdy low for 10 clocks on byte 0
    o0 = out_log.size();
    out_rdy = 1'b0;
    start(1'b1, 1'b0, 16'hD100, 11'd2);
    n = 0;
    while (!out_vld && n < 50) begin
      n++;
      tick();
    end
    check("bp_vld_seen", 32'(out_vld), 32'h1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_vld && out_dat == 8'hC1 && !PAUSE_N) n++;
      tick();
    end
    check("bp_hold", 32'(n), 32'd10);
    out_rdy = 1'b1;
    wait_done("bp_done", m);
    tick();
    check("bp_nbytes", 32'(out_log.size() - o0), 32'h2);
    check("bp_bytes", 32'({ob(o0), ob(o0 + 1)}), 32'hC1C2);

    // simultaneous requests, then a load_req while busy
    o0 = out_log.size(); d0 = done_cnt; w0 = hswe_cnt;
    start(1'b1, 1'b1, HS_SPRAM_BASE, 11'd2);
    tick(); tick();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    wait_done("both_done", m);
    repeat (20) tick();
    check("both_done_once", 32'(done_cnt - d0), 32'h1);
    check("both_no_hswe", 32'(hswe_cnt - w0), 32'h0);
    check("both_bytes", 32'({ob(o0), ob(o0 + 1)}), 32'h1122);
    check("both_idle", 32'({busy, PAUSE_N}), 32'b01);

    // len 0: PAUSE_N low for the settle clocks plus the RELEASE clock, no access
    a0 = addr_log.size(); v0 = ovld_cnt; d0 = done_cnt;
    start(1'b1, 1'b0, 16'h1234, 11'd0);
    n = 0;
    while (PAUSE_N == 1'b0 && n < 50) begin
      n++;
      tick();
    end
    check("z_pause_clks", 32'(n), 32'(HS_SETTLE + 1));
    check("z_done", 32'(done), 32'h1);
    tick(); tick();
    check("z_no_addr", 32'(addr_log.size() - a0), 32'h0);
    check("z_no_vld", 32'(ovld_cnt - v0), 32'h0);
    check("z_done_once", 32'(done_cnt - d0), 32'h1);

    // address wrap FFFF -> 0000
    o0 = out_log.size(); a0 = addr_log.size();
    start(1'b1, 1'b0, 16'hFFFF, 11'd2);
    wait_done("wrap_done", m);
    check("wrap_addr", {ab(a0), ab(a0 + 1)}, 32'hFFFF0000);
    check("wrap_bytes", 32'({ob(o0), ob(o0 + 1)}), 32'h7788);

    // reset in the middle of a restore, after the first byte
    w0 = hswe_cnt;
    start(1'b0, 1'b1, HS_VRAM0_BASE, 11'd3);
    push_byte("mr_b0_rdy", 0, 8'hA1);
    tick(); tick();
    d0 = done_cnt;
    RESET = 1'b1;
    tick();
    check("mr_ctrl", 32'({PAUSE_N, HSWE, busy, done, in_rdy}), 32'b10000);
    RESET = 1'b0;
    repeat (5) tick();
    check("mr_no_done", 32'(done_cnt - d0), 32'h0);
    check("mr_one_wr", 32'(hswe_cnt - w0), 32'h1);
    check("mr_mem", 32'(mem[16'hE000]), 32'hA1);

    // normal dump after the abort
    o0 = out_log.size(); d0 = done_cnt;
    start(1'b1, 1'b0, HS_SPRAM_BASE, 11'd4);
    wait_done("ad_done", m);
    tick();
    check("ad_bytes", {ob(o0), ob(o0 + 1), ob(o0 + 2), ob(o0 + 3)}, 32'h11223344);
    check("ad_done_once", 32'(done_cnt - d0), 32'h1);

    check("hswe_only_paused", 32'(hswe_unpaused), 32'h0);
    check("in_rdy_eq_hswe", 32'(rdy_mis), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
